// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: Montgomery modular-exponentiation sequencer.
// Computes z = x^e mod m by left-to-right square-and-multiply. It drives an
// external Montgomery multiplier (which holds m) through a start/done
// handshake and keeps every intermediate value in the Montgomery domain.
// Optional build macro: MOD_EXP_SKIP_LEADING_ZEROS_EN. When it is defined,
// leading zero bits of e are skipped without multiplier operations, and the
// first squaring is dropped because it would only square R mod m.
module mod_exp_ctrl #(
    parameter int K     = 192,
    parameter int EW    = 192,
    parameter int LOGEW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [K-1:0]      x,
    input  logic [EW-1:0]     e,
    input  logic [K-1:0]      r2,
    output logic [K-1:0]      z,
    output logic              busy,
    output logic              done,
    output logic [15:0]       op_cnt,
    output logic [K-1:0]      mm_x,
    output logic [K-1:0]      mm_y,
    output logic              mm_start,
    input  logic [K-1:0]      mm_z,
    input  logic              mm_done
);

    localparam logic [K-1:0]     ONE     = K'(1);
    localparam logic [LOGEW-1:0] TOP_BIT = LOGEW'(EW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV_X,
        S_CONV_ONE,
        S_SCAN,
        S_SQR,
        S_MUL,
        S_POST,
        S_FIN
    } state_t;

    // Handshake phase of the multiplier operation owned by the current state.
    typedef enum logic [1:0] {
        P_ISSUE,
        P_WAIT_LO,
        P_WAIT_HI
    } phase_t;

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    logic [LOGEW-1:0] idx_q, idx_d;
    logic [K-1:0]     x_q, x_d;
    logic [EW-1:0]    e_q, e_d;
    logic [K-1:0]     r2_q, r2_d;
    logic [K-1:0]     xb_q, xb_d;
    logic [K-1:0]     acc_q, acc_d;
    logic [K-1:0]     z_q, z_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [15:0]      op_cnt_q, op_cnt_d;
    logic [K-1:0]     mm_x_q, mm_x_d;
    logic [K-1:0]     mm_y_q, mm_y_d;
    logic             mm_start_q, mm_start_d;

    logic [K-1:0]     op_x;
    logic [K-1:0]     op_y;
    logic             last_bit;

    // Operand pair for the multiplier operation belonging to each state.
    always_comb begin
        op_x = '0;
        op_y = '0;
        case (state_q)
            S_CONV_X:   begin op_x = x_q;   op_y = r2_q;  end
            S_CONV_ONE: begin op_x = r2_q;  op_y = ONE;   end
            S_SQR:      begin op_x = acc_q; op_y = acc_q; end
            S_MUL:      begin op_x = acc_q; op_y = xb_q;  end
            S_POST:     begin op_x = acc_q; op_y = ONE;   end
            default:    ;
        endcase
    end

    // Next-state logic for the job sequence and the per-operation handshake.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case statements can leave one unassigned and infer a latch.
        state_d    = state_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        x_d        = x_q;
        e_d        = e_q;
        r2_d       = r2_q;
        xb_d       = xb_q;
        acc_d      = acc_q;
        z_d        = z_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        op_cnt_d   = op_cnt_q;
        mm_x_d     = mm_x_q;
        mm_y_d     = mm_y_q;
        mm_start_d = mm_start_q;
        last_bit   = (idx_q == '0);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d      = x;
                    e_d      = e;
                    r2_d     = r2;
                    op_cnt_d = '0;
                    busy_d   = 1'b1;
                    idx_d    = TOP_BIT;
                    phase_d  = P_ISSUE;
                    state_d  = S_CONV_X;
                end
            end

            S_SCAN: begin
                phase_d = P_ISSUE;
`ifdef MOD_EXP_SKIP_LEADING_ZEROS_EN
                // acc still holds R mod m here, so the first set bit needs
                // only its multiply; e = 0 falls straight through to POST.
                if (e_q[idx_q]) begin
                    state_d = S_MUL;
                end else if (last_bit) begin
                    state_d = S_POST;
                end else begin
                    idx_d = idx_q - LOGEW'(1);
                end
`else
                state_d = S_SQR;
`endif
            end

            S_FIN: begin
                z_d     = acc_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                case (phase_q)
                    // A cycle here with mm_start low and mm_done high re-arms
                    // the multiplier; a stale low mm_done simply waits.
                    P_ISSUE: begin
                        if (mm_done) begin
                            mm_x_d     = op_x;
                            mm_y_d     = op_y;
                            mm_start_d = 1'b1;
                            phase_d    = P_WAIT_LO;
                        end
                    end

                    P_WAIT_LO: begin
                        if (!mm_done) begin
                            mm_start_d = 1'b0;
                            phase_d    = P_WAIT_HI;
                        end
                    end

                    P_WAIT_HI: begin
                        if (mm_done) begin
                            phase_d  = P_ISSUE;
                            op_cnt_d = (op_cnt_q == 16'hFFFF) ? op_cnt_q
                                                              : op_cnt_q + 16'd1;
                            if (state_q == S_CONV_X) begin
                                xb_d = mm_z;
                            end else begin
                                acc_d = mm_z;
                            end

                            case (state_q)
                                S_CONV_X:   state_d = S_CONV_ONE;
                                S_CONV_ONE: state_d = S_SCAN;
                                S_SQR: begin
                                    if (e_q[idx_q]) begin
                                        state_d = S_MUL;
                                    end else if (last_bit) begin
                                        state_d = S_POST;
                                    end else begin
                                        idx_d   = idx_q - LOGEW'(1);
                                        state_d = S_SQR;
                                    end
                                end
                                S_MUL: begin
                                    if (last_bit) begin
                                        state_d = S_POST;
                                    end else begin
                                        idx_d   = idx_q - LOGEW'(1);
                                        state_d = S_SQR;
                                    end
                                end
                                S_POST:     state_d = S_FIN;
                                default:    ;
                            endcase
                        end
                    end

                    default: phase_d = P_ISSUE;
                endcase
            end
        endcase
    end

    // Control and output registers; reset aborts any job immediately.
    always_ff @(posedge clk) begin
        // NOTE: registers are written with non-blocking assignments so every
        // flop samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q    <= S_IDLE;
            phase_q    <= P_ISSUE;
            idx_q      <= TOP_BIT;
            z_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            op_cnt_q   <= '0;
            mm_x_q     <= '0;
            mm_y_q     <= '0;
            mm_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            z_q        <= z_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            op_cnt_q   <= op_cnt_d;
            mm_x_q     <= mm_x_d;
            mm_y_q     <= mm_y_d;
            mm_start_q <= mm_start_d;
        end
    end

    // Job operands and Montgomery-domain intermediates.
    always_ff @(posedge clk) begin
        // NOTE: these wide data registers are deliberately not reset; each is
        // written at job accept or by a capture before anything reads it.
        x_q   <= x_d;
        e_q   <= e_d;
        r2_q  <= r2_d;
        xb_q  <= xb_d;
        acc_q <= acc_d;
    end

    assign z        = z_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign op_cnt   = op_cnt_q;
    assign mm_x     = mm_x_q;
    assign mm_y     = mm_y_q;
    assign mm_start = mm_start_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb_mod_exp_ctrl: scoreboard bench for mod_exp_ctrl with a behavioural
// Montgomery multiplier for m = P-192. Expected results are hand-computed
// constants pushed when a job is issued; a monitor pops them on done.
module tb_mod_exp_ctrl;

    localparam int K     = 192;
    localparam int EW    = 192;
    localparam int LOGEW = 8;

    // m = 2^192 - 2^64 - 1, R mod m = 2^64 + 1, R^2 mod m = 2^128 + 2^65 + 1.
    localparam logic [K-1:0] M   = 192'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFE_FFFFFFFFFFFFFFFF;
    localparam logic [K-1:0] R2  = 192'h0000000000000001_0000000000000002_0000000000000001;
    // 2 * R mod m: Montgomery form of x = 2, used to spot the first MUL.
    localparam logic [K-1:0] XB2 = 192'h0000000000000000_0000000000000002_0000000000000002;

`ifdef MOD_EXP_SKIP_LEADING_ZEROS_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [K-1:0] z;
        logic [15:0]  ops;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          mm_reset;
    logic          start;
    logic [K-1:0]  x;
    logic [EW-1:0] e;
    logic [K-1:0]  r2;
    logic [K-1:0]  z;
    logic          busy;
    logic          done;
    logic [15:0]   op_cnt;
    logic [K-1:0]  mm_x;
    logic [K-1:0]  mm_y;
    logic          mm_start;
    logic [K-1:0]  mm_z;
    logic          mm_done;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    // Multiplier model state.
    logic          mm_busy;
    logic          armed;
    logic          stale;
    logic          abort_arm;
    logic          mul_hit = 1'b0;
    logic          rst_at_edge = 1'b0;
    int            mm_cnt;
    int            n_accept = 0;
    logic [K-1:0]  lat_x;
    logic [K-1:0]  lat_y;

    mod_exp_ctrl #(.K(K), .EW(EW), .LOGEW(LOGEW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .x        (x),
        .e        (e),
        .r2       (r2),
        .z        (z),
        .busy     (busy),
        .done     (done),
        .op_cnt   (op_cnt),
        .mm_x     (mm_x),
        .mm_y     (mm_y),
        .mm_start (mm_start),
        .mm_z     (mm_z),
        .mm_done  (mm_done)
    );

    always #5 clk = ~clk;

    // Bit-serial Montgomery product a * b * 2^-K mod M.
    function automatic logic [K-1:0] mont(input logic [K-1:0] a, input logic [K-1:0] b);
        logic [K+1:0] t;
        t = '0;
        for (int i = 0; i < K; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, M};
            t = t >> 1;
        end
        if (t >= {2'b00, M}) t = t - {2'b00, M};
        return t[K-1:0];
    endfunction

    function automatic logic [15:0] ops(input int with_skip, input int without_skip);
        return SKIP_EN ? 16'(with_skip) : 16'(without_skip);
    endfunction

    task automatic check_val(input string name, input logic [K-1:0] act, input logic [K-1:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic expect_job(input logic [K-1:0] zv, input logic [15:0] opv);
        exp_t ex;
        ex.z   = zv;
        ex.ops = opv;
        sb.push_back(ex);
    endtask

    task automatic start_job(input logic [K-1:0] xv, input logic [EW-1:0] ev);
        @(negedge clk);
        x     = xv;
        e     = ev;
        r2    = R2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_val({name, "_timeout"}, K'(n >= 20000), '0);
        repeat (3) @(negedge clk);
    endtask

    // Multiplier model: accepts a re-armed start, drops done for a few cycles,
    // then returns the Montgomery product. Its reset is separate from the
    // controller's so an aborted job can leave it mid-operation.
    always @(posedge clk) begin
        rst_at_edge <= reset;
        mul_hit     <= mul_hit && abort_arm;
        if (mm_reset) begin
            mm_done <= 1'b1;
            mm_busy <= 1'b0;
            armed   <= 1'b0;
            stale   <= 1'b0;
            mm_cnt  <= 0;
            mm_z    <= '0;
        end else if (mm_busy) begin
            if (reset) stale <= 1'b1;
            if (mm_cnt <= 1) begin
                mm_busy <= 1'b0;
                mm_done <= 1'b1;
                mm_z    <= mont(lat_x, lat_y);
            end else begin
                mm_cnt <= mm_cnt - 1;
            end
        end else if (mm_start === 1'b1 && armed) begin
            lat_x    <= mm_x;
            lat_y    <= mm_y;
            mm_busy  <= 1'b1;
            mm_done  <= 1'b0;
            armed    <= 1'b0;
            stale    <= 1'b0;
            n_accept <= n_accept + 1;
            if (abort_arm && mm_y == XB2 && mm_x != mm_y) begin
                mm_cnt  <= 20;
                mul_hit <= 1'b1;
            end else begin
                mm_cnt <= 1 + (n_accept % 4);
            end
        end else if (mm_start === 1'b0) begin
            armed <= 1'b1;
        end
    end

    // Handshake checker on every multiplier operation.
    initial begin
        logic        prev_start = 1'b0;
        logic        prev_done  = 1'b1;
        logic [15:0] prev_ops   = '0;
        logic        low_seen   = 1'b0;
        forever begin
            @(negedge clk);
            if (mm_reset === 1'b0) begin
                if (prev_start === 1'b1 && mm_start === 1'b0 && !rst_at_edge)
                    check_val("mm_start_fall_after_done_lo", K'(prev_done), K'(1'b0));
                if (prev_done === 1'b0 && mm_done === 1'b1 && !stale) begin
                    check_val("mm_x_stable", mm_x, lat_x);
                    check_val("mm_y_stable", mm_y, lat_y);
                end
                if (op_cnt === prev_ops + 16'd1) begin
                    check_val("capture_after_lo_hi", K'(prev_done && low_seen), K'(1'b1));
                    low_seen = 1'b0;
                end
                if (mm_done === 1'b0) low_seen = 1'b1;
            end
            prev_start = mm_start;
            prev_done  = mm_done;
            prev_ops   = op_cnt;
        end
    end

    // Scoreboard monitor: every done pops one expected job.
    initial begin
        exp_t ex;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1, expected no pending job");
                end else begin
                    ex = sb.pop_front();
                    check_val("z", z, ex.z);
                    check_val("op_cnt", K'(op_cnt), K'(ex.ops));
                end
                @(negedge clk);
                check_val("done_single_cycle", K'(done), '0);
                check_val("busy_after_done", K'(busy), '0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of run, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset     = 1'b1;
        mm_reset  = 1'b1;
        start     = 1'b0;
        x         = '0;
        e         = '0;
        r2        = '0;
        abort_arm = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_z", z, '0);
        check_val("rst_busy", K'(busy), '0);
        check_val("rst_done", K'(done), '0);
        check_val("rst_op_cnt", K'(op_cnt), '0);
        check_val("rst_mm_start", K'(mm_start), '0);
        check_val("rst_mm_x", mm_x, '0);
        check_val("rst_mm_y", mm_y, '0);
        reset    = 1'b0;
        mm_reset = 1'b0;

        // Case 1: 2^10.
        expect_job(K'(1024), ops(8, 197));
        start_job(K'(2), EW'(10));
        wait_done("case1");

        // Case 2: e = 0 gives 1.
        expect_job(K'(1), ops(3, 195));
        start_job(K'(5), EW'(0));
        wait_done("case2");

        // Case 3: (m-1)^1 and 0^5.
        expect_job(M - K'(1), ops(4, 196));
        start_job(M - K'(1), EW'(1));
        wait_done("case3a");
        expect_job(K'(0), ops(7, 197));
        start_job(K'(0), EW'(5));
        wait_done("case3b");

        // Case 4: starts while busy are ignored; 7^3 = 343.
        expect_job(K'(343), ops(6, 197));
        start_job(K'(7), EW'(3));
        repeat (2) @(negedge clk);
        check_val("busy_during_job", K'(busy), K'(1'b1));
        start_job(K'(5), EW'(7));
        repeat (3) @(negedge clk);
        start_job(K'(9), EW'(2));
        wait_done("case4");

        // Case 5: abort during the first MUL wait, then 3^4 = 81 while the
        // multiplier is still finishing the aborted operation.
        abort_arm = 1'b1;
        start_job(K'(2), EW'(10));
        n = 0;
        while (mul_hit !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_val("case5_mul_reached", K'(n >= 20000), '0);
        abort_arm = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        check_val("abort_busy", K'(busy), '0);
        check_val("abort_mm_start", K'(mm_start), '0);
        check_val("abort_z", z, '0);
        check_val("abort_done", K'(done), '0);
        reset = 1'b0;
        expect_job(K'(81), ops(6, 196));
        start_job(K'(3), EW'(4));
        wait_done("case5");

        repeat (5) @(negedge clk);
        check_val("scoreboard_empty", K'(sb.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
